// File: rtl/outlier_drain.sv
// -----------------------------------------------------------------------------
// outlier_drain
//
// Read side of the outlier-position FIFO. After a start pulse the block pops
// point indices from a standard-mode FIFO (data valid the cycle after the read
// strobe), discards indices at or beyond point_cloud_size, and re-emits the
// survivors on a valid/ready stream. The final index carries m_last once the
// controller has reported done and the FIFO is fully drained.
//
// Ports
//   clock, reset        single clock; asynchronous active-low reset
//   start               one-cycle pulse, arms a session (IDLE/DONE only)
//   ctrl_done           controller done level
//   point_cloud_size    2N-bit exclusive upper limit for kept indices
//   fifo_dout/empty     FIFO read data and empty flag
//   fifo_rd_en          FIFO read strobe
//   m_valid/m_ready/m_data/m_last   output stream
//   outlier_count       handshakes this session (saturating)
//   drop_count          discarded indices this session (saturating)
//   finished            session complete, held until the next start
// -----------------------------------------------------------------------------
module outlier_drain #(
  parameter int N         = 16,
  parameter int BUF_DEPTH = 3
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           ctrl_done,
  input  logic [2*N-1:0] point_cloud_size,
  input  logic [N-1:0]   fifo_dout,
  input  logic           fifo_empty,
  output logic           fifo_rd_en,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [N-1:0]   m_data,
  output logic           m_last,
  output logic [N-1:0]   outlier_count,
  output logic [N-1:0]   drop_count,
  output logic           finished
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [1:0] LAST_SLOT = 2'(BUF_DEPTH - 1);
  localparam logic [2:0] DEPTH     = 3'(BUF_DEPTH);

  state_t       state;
  logic [N-1:0] buf_mem [BUF_DEPTH];
  logic [1:0]   head;
  logic [1:0]   tail;
  logic [1:0]   cnt;
  logic         inflight;

  logic         pop;
  logic         push;
  logic         dropped;
  logic         end_cond;
  logic [2:0]   occ_est;
  logic [1:0]   cnt_next;

  // The head is only offered when a successor is already buffered, or when the
  // session is flushing and it is the very last entry. That way m_last is
  // known at the moment m_valid rises and never changes while held.
  assign m_valid = (cnt >= 2'd2) || ((state == S_FLUSH) && (cnt == 2'd1));
  assign m_last  = (state == S_FLUSH) && (cnt == 2'd1);
  assign m_data  = buf_mem[head];

  assign pop      = m_valid && m_ready;
  // Occupancy the buffer will have once the outstanding read lands and this
  // cycle's pop retires; a new read is only safe if that leaves a free slot.
  assign occ_est  = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = (state == S_DRAIN) && !fifo_empty && (occ_est < DEPTH);

  // Returned word is zero-extended so the full 2N-bit limit is honoured.
  assign push     = inflight && ({{N{1'b0}}, fifo_dout} < point_cloud_size);
  assign dropped  = inflight && !push;
  assign end_cond = ctrl_done && fifo_empty && !inflight;
  assign cnt_next = cnt + {1'b0, push} - {1'b0, pop};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      head          <= '0;
      tail          <= '0;
      cnt           <= '0;
      inflight      <= 1'b0;
      outlier_count <= '0;
      drop_count    <= '0;
      finished      <= 1'b0;
      // NOTE: the buffer is small and drives m_data directly, so it is reset
      // to keep m_data at zero while reset is asserted.
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_mem[i] <= '0;
      end
    end else begin
      inflight <= fifo_rd_en;
      cnt      <= cnt_next;

      if (push) begin
        buf_mem[tail] <= fifo_dout;
        tail          <= (tail == LAST_SLOT) ? 2'd0 : tail + 2'd1;
      end
      if (pop) begin
        head <= (head == LAST_SLOT) ? 2'd0 : head + 2'd1;
      end
      if (pop && (outlier_count != '1)) begin
        outlier_count <= outlier_count + 1'b1;
      end
      if (dropped && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end

      unique case (state)
        S_IDLE, S_DONE: begin
          // No reads or pops happen here, so these clears cannot collide
          // with the updates above.
          if (start) begin
            state         <= S_DRAIN;
            head          <= '0;
            tail          <= '0;
            cnt           <= '0;
            outlier_count <= '0;
            drop_count    <= '0;
            finished      <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (end_cond) begin
            state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (cnt_next == 2'd0) begin
            state    <= S_DONE;
            finished <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_outlier_drain.sv
// -----------------------------------------------------------------------------
// tb_outlier_drain
//
// Directed bench for outlier_drain. A table of sessions (FIFO contents, index
// limit, done/ready timing, expected stream and counts) is replayed in a loop
// against a behavioural standard-mode FIFO; an asynchronous-reset sequence is
// written out by hand. Inputs change 1 time unit after the rising edge and the
// stream is observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_outlier_drain;

  localparam int N = 16;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           ctrl_done = 1'b0;
  logic [2*N-1:0] point_cloud_size = '0;
  logic [N-1:0]   fifo_dout = '0;
  logic           fifo_empty;
  logic           fifo_rd_en;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic [N-1:0]   m_data;
  logic           m_last;
  logic [N-1:0]   outlier_count;
  logic [N-1:0]   drop_count;
  logic           finished;

  int n_applied = 0;
  int n_fail    = 0;

  outlier_drain #(.N(N), .BUF_DEPTH(3)) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .ctrl_done        (ctrl_done),
    .point_cloud_size (point_cloud_size),
    .fifo_dout        (fifo_dout),
    .fifo_empty       (fifo_empty),
    .fifo_rd_en       (fifo_rd_en),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_data           (m_data),
    .m_last           (m_last),
    .outlier_count    (outlier_count),
    .drop_count       (drop_count),
    .finished         (finished)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Standard-mode FIFO: dout updates on the edge that samples rd_en.
  logic [N-1:0] fifo_mem [64];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int reads  = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clock) begin
    if (fifo_rd_en) begin
      check("rd_while_empty", 32'(fifo_empty), 32'd0);
      fifo_dout <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
      reads     <= reads + 1;
    end
  end

  // Stream monitor: records handshakes and checks stability while held.
  logic [N-1:0] cap_data [$];
  logic         cap_last [$];
  bit           saw_valid = 1'b0;
  bit           prev_hold = 1'b0;
  logic [N-1:0] prev_data = '0;
  logic         prev_last = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      if (prev_hold) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data",  32'(m_data),  32'(prev_data));
        check("hold_last",  32'(m_last),  32'(prev_last));
      end
      if (m_valid) saw_valid = 1'b1;
      if (m_valid && m_ready) begin
        cap_data.push_back(m_data);
        cap_last.push_back(m_last);
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
    end else begin
      prev_hold = 1'b0;
    end
  end

  typedef struct {
    string       name;
    int          n_in;
    logic [31:0] in_data [6];
    logic [31:0] size;
    int          done_delay;     // 0: ctrl_done high from start
    int          ready_hold;     // 0: m_ready high from start
    int          exp_hold_reads; // reads issued when m_ready rises
    int          finish_by;      // 0: no deadline check
    int          n_out;
    logic [31:0] out_data [6];
    int          exp_drop;
  } vec_t;

  vec_t vecs [8];

  task automatic load_fifo(input int n, input logic [31:0] d [6]);
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_ptr] = 16'(d[i]);
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    int reads0;
    bit done_seen;
    load_fifo(v.n_in, v.in_data);
    point_cloud_size = v.size;
    ctrl_done = (v.done_delay == 0);
    m_ready   = (v.ready_hold == 0);
    cap_data.delete();
    cap_last.delete();
    saw_valid = 1'b0;
    reads0 = reads;
    pulse_start();
    check({v.name, ":finished_cleared"}, 32'(finished), 32'd0);
    check({v.name, ":outliers_cleared"}, 32'(outlier_count), 32'd0);
    check({v.name, ":drops_cleared"},    32'(drop_count), 32'd0);
    cyc = 0;
    done_seen = 1'b0;
    while (cyc < 400 && !done_seen) begin
      @(posedge clock);
      #1;
      cyc++;
      if (v.ready_hold > 0 && cyc == v.ready_hold) begin
        check({v.name, ":reads_while_held"}, 32'(reads - reads0), 32'(v.exp_hold_reads));
        m_ready = 1'b1;
      end
      if (v.done_delay > 0 && cyc == v.done_delay) begin
        check({v.name, ":early_outputs"}, 32'(cap_data.size()), 32'(v.n_out - 1));
        check({v.name, ":lone_head_held"}, 32'(m_valid), 32'd0);
        ctrl_done = 1'b1;
      end
      if (v.finish_by > 0 && cyc == v.finish_by)
        check({v.name, ":finished_by_deadline"}, 32'(finished), 32'd1);
      if (finished) done_seen = 1'b1;
    end
    check({v.name, ":session_completed"}, 32'(done_seen), 32'd1);
    check({v.name, ":stream_len"}, 32'(cap_data.size()), 32'(v.n_out));
    for (int i = 0; i < v.n_out && i < cap_data.size(); i++) begin
      check($sformatf("%s:data[%0d]", v.name, i), 32'(cap_data[i]), v.out_data[i]);
      check($sformatf("%s:last[%0d]", v.name, i), 32'(cap_last[i]), 32'(i == v.n_out - 1));
    end
    check({v.name, ":saw_valid"},     32'(saw_valid), 32'(v.n_out > 0));
    check({v.name, ":outlier_count"}, 32'(outlier_count), 32'(v.n_out));
    check({v.name, ":drop_count"},    32'(drop_count), 32'(v.exp_drop));
    check({v.name, ":fifo_drained"},  32'(fifo_empty), 32'd1);
    ctrl_done = 1'b0;
  endtask

  initial begin
    logic [31:0] rst_in [6];

    vecs[0] = '{name:"three", n_in:3, in_data:'{5, 9, 12, 0, 0, 0}, size:100,
                done_delay:0, ready_hold:0, exp_hold_reads:0, finish_by:0,
                n_out:3, out_data:'{5, 9, 12, 0, 0, 0}, exp_drop:0};
    vecs[1] = '{name:"none", n_in:0, in_data:'{0, 0, 0, 0, 0, 0}, size:100,
                done_delay:0, ready_hold:0, exp_hold_reads:0, finish_by:3,
                n_out:0, out_data:'{0, 0, 0, 0, 0, 0}, exp_drop:0};
    vecs[2] = '{name:"backpressure", n_in:6, in_data:'{11, 22, 33, 44, 55, 66}, size:100,
                done_delay:0, ready_hold:10, exp_hold_reads:3, finish_by:0,
                n_out:6, out_data:'{11, 22, 33, 44, 55, 66}, exp_drop:0};
    vecs[3] = '{name:"range", n_in:3, in_data:'{4, 200, 7, 0, 0, 0}, size:100,
                done_delay:0, ready_hold:0, exp_hold_reads:0, finish_by:0,
                n_out:2, out_data:'{4, 7, 0, 0, 0, 0}, exp_drop:1};
    vecs[4] = '{name:"late_done", n_in:2, in_data:'{3, 8, 0, 0, 0, 0}, size:100,
                done_delay:20, ready_hold:0, exp_hold_reads:0, finish_by:0,
                n_out:2, out_data:'{3, 8, 0, 0, 0, 0}, exp_drop:0};
    vecs[5] = '{name:"limit_edge", n_in:3, in_data:'{99, 100, 0, 0, 0, 0}, size:100,
                done_delay:0, ready_hold:0, exp_hold_reads:0, finish_by:0,
                n_out:2, out_data:'{99, 0, 0, 0, 0, 0}, exp_drop:1};
    vecs[6] = '{name:"wide_limit", n_in:2, in_data:'{32'hFFFF, 32'h1234, 0, 0, 0, 0}, size:32'h0001_0000,
                done_delay:0, ready_hold:0, exp_hold_reads:0, finish_by:0,
                n_out:2, out_data:'{32'hFFFF, 32'h1234, 0, 0, 0, 0}, exp_drop:0};
    vecs[7] = '{name:"all_dropped", n_in:2, in_data:'{100, 300, 0, 0, 0, 0}, size:100,
                done_delay:0, ready_hold:0, exp_hold_reads:0, finish_by:0,
                n_out:0, out_data:'{0, 0, 0, 0, 0, 0}, exp_drop:2};

    // Reset state.
    @(posedge clock);
    @(posedge clock);
    #1;
    check("rst:fifo_rd_en",    32'(fifo_rd_en), 32'd0);
    check("rst:m_valid",       32'(m_valid), 32'd0);
    check("rst:m_last",        32'(m_last), 32'd0);
    check("rst:m_data",        32'(m_data), 32'd0);
    check("rst:outlier_count", 32'(outlier_count), 32'd0);
    check("rst:drop_count",    32'(drop_count), 32'd0);
    check("rst:finished",      32'(finished), 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    for (int k = 0; k < 8; k++) begin
      run_vec(vecs[k]);
    end

    // Asynchronous reset while a word is being offered and held.
    rst_in = '{10, 20, 30, 0, 0, 0};
    load_fifo(3, rst_in);
    point_cloud_size = 100;
    ctrl_done = 1'b0;
    m_ready   = 1'b0;
    pulse_start();
    repeat (8) @(posedge clock);
    #1;
    check("mid:m_valid", 32'(m_valid), 32'd1);
    check("mid:m_data",  32'(m_data), 32'd10);
    #1 reset = 1'b0;
    #1;
    check("async:m_valid",       32'(m_valid), 32'd0);
    check("async:m_last",        32'(m_last), 32'd0);
    check("async:m_data",        32'(m_data), 32'd0);
    check("async:fifo_rd_en",    32'(fifo_rd_en), 32'd0);
    check("async:outlier_count", 32'(outlier_count), 32'd0);
    check("async:drop_count",    32'(drop_count), 32'd0);
    check("async:finished",      32'(finished), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    run_vec('{name:"after_reset", n_in:2, in_data:'{1, 2, 0, 0, 0, 0}, size:100,
              done_delay:0, ready_hold:0, exp_hold_reads:0, finish_by:0,
              n_out:2, out_data:'{1, 2, 0, 0, 0, 0}, exp_drop:0});

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule
